// File: rtl/cast_rr_arbiter_pkg.sv
// Shared types for the round-robin cast arbiter: state encoding, id and word types,
// and the narrowing cast used on the granted word.
package cast_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IN_W  = 8;
  localparam int OUT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_t;

  typedef logic [1:0] req_id_t;
  typedef logic [3:0] out_word_t;
  typedef logic [7:0] in_word_t;

  // Keeps the low OUT_W bits; no sign extension, no rounding.
  function automatic out_word_t cast_word(input in_word_t w);
    return out_word_t'(w);
  endfunction

endpackage

// File: rtl/cast_rr_arbiter_if.sv
// Request/grant and result port bundle for cast_rr_arbiter.
// out_valid/out_ready: a transfer happens on a cycle where both are high; until then
// out_valid stays high and out_data/out_id stay stable.
interface cast_rr_arbiter_if;
  import cast_arb_pkg::*;

  logic [N_REQ-1:0]      req;
  logic [N_REQ*IN_W-1:0] req_data;
  logic [N_REQ-1:0]      gnt;
  logic                  out_valid;
  logic                  out_ready;
  out_word_t             out_data;
  req_id_t               out_id;

  modport master (
    output req, req_data, out_ready,
    input  gnt, out_valid, out_data, out_id
  );

  modport slave (
    input  req, req_data, out_ready,
    output gnt, out_valid, out_data, out_id
  );

endinterface

// File: rtl/cast_rr_arbiter_rr_pick.sv
// Combinational round-robin priority rotator: first asserted request after last_id wins.
module rr_pick
  import cast_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  req_id_t          last_id,
  output logic             valid,
  output req_id_t          id
);

  req_id_t cand;

  always_comb begin
    valid = 1'b0;
    id    = last_id;
    cand  = last_id;
    // i == N_REQ wraps back to last_id, so it is searched last.
    for (int i = 1; i <= N_REQ; i++) begin
      cand = last_id + req_id_t'(i);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        id    = cand;
      end
    end
  end

endmodule

// File: rtl/cast_rr_arbiter.sv
// Round-robin arbiter sharing one narrowing-cast datapath between four requesters.
// IDLE arbitrates and captures, GRANT pulses gnt, DONE presents the result.
module cast_rr_arbiter
  import cast_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  cast_rr_arbiter_if.slave  bus,
  output logic              busy,
  output arb_state_t        state_dbg
);

  arb_state_t state;
  req_id_t    last_id;
  req_id_t    cur_id;
  req_id_t    pick_id;
  logic       pick_valid;
  out_word_t  result;
  in_word_t   pick_word;

  rr_pick u_pick (
    .req     (bus.req),
    .last_id (last_id),
    .valid   (pick_valid),
    .id      (pick_id)
  );

  always_comb begin
    pick_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_id == req_id_t'(i)) pick_word = bus.req_data[i*IN_W +: IN_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      bus.gnt       <= '0;
      bus.out_valid <= 1'b0;
      result        <= '0;
      cur_id        <= '0;
      last_id       <= req_id_t'(N_REQ - 1);
      busy          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state   <= ST_GRANT;
            cur_id  <= pick_id;
            last_id <= pick_id;
            result  <= cast_word(pick_word);
            bus.gnt <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_id;
            busy    <= 1'b1;
          end
        end
        ST_GRANT: begin
          state         <= ST_DONE;
          bus.gnt       <= '0;
          bus.out_valid <= 1'b1;
        end
        ST_DONE: begin
          // Result and id stay put after the handshake; only valid drops.
          if (bus.out_ready) begin
            state         <= ST_IDLE;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          bus.gnt       <= '0;
          bus.out_valid <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data = result;
  assign bus.out_id   = cur_id;
  assign state_dbg    = state;

endmodule

// File: tb/tb_cast_rr_arbiter.sv
// Bench for cast_rr_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_cast_rr_arbiter;
  import cast_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  arb_state_t state_dbg;

  cast_rr_arbiter_if bus();

  cast_rr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model + scoreboard ----------------
  logic [5:0]  exp_q[$];          // {id, cast word} of accepted transfers, oldest first
  logic        model_live = 1'b0;
  logic        m_in_flight;
  logic        m_valid;
  logic [3:0]  m_gnt;
  logic [3:0]  m_data;
  int          m_id;
  int          m_last;
  logic        s_rst, s_rdy;
  logic [3:0]  s_req;
  logic [31:0] s_data;

  task automatic model_step();
    int w;
    if (s_rst) begin
      model_live  = 1'b1;
      m_in_flight = 1'b0;
      m_valid     = 1'b0;
      m_gnt       = '0;
      m_data      = '0;
      m_id        = 0;
      m_last      = 3;
      exp_q.delete();
    end else if (model_live) begin
      m_gnt = '0;
      if (m_in_flight) begin
        if (!m_valid) m_valid = 1'b1;
        else if (s_rdy) begin
          m_valid     = 1'b0;
          m_in_flight = 1'b0;
          void'(exp_q.pop_front());
        end
      end else if (s_req != 4'b0000) begin
        w = -1;
        for (int k = 1; k <= 4; k++) begin
          if (w < 0 && s_req[(m_last + k) % 4]) w = (m_last + k) % 4;
        end
        m_gnt[w]    = 1'b1;
        m_id        = w;
        m_data      = s_data[w*8 +: 4];
        m_last      = w;
        m_in_flight = 1'b1;
        exp_q.push_back({2'(w), s_data[w*8 +: 4]});
      end
    end
  endtask

  task automatic compare_outputs();
    int exp_st;
    exp_st = !m_in_flight ? 0 : (m_valid ? 2 : 1);
    chk("gnt",       bus.gnt,       m_gnt);
    chk("out_valid", bus.out_valid, m_valid);
    chk("busy",      busy,          m_in_flight);
    chk("state",     state_dbg,     exp_st);
    chk("out_id",    bus.out_id,    m_id);
    chk("out_data",  bus.out_data,  m_data);
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_valid", 1, 0);
      else chk("sb_payload", {bus.out_id, bus.out_data}, exp_q[0]);
    end
  endtask

  always begin
    @(posedge clk);
    s_rst  = rst;
    s_req  = bus.req;
    s_data = bus.req_data;
    s_rdy  = bus.out_ready;
    model_step();
    #1;
    if (model_live) compare_outputs();
  end

  // ---------------- driver tasks ----------------
  int g_ids[$];
  int g_cyc[$];
  int g_dat[$];

  task automatic set_word(input int i, input logic [7:0] w);
    bus.req_data[i*8 +: 8] = w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.req = '0;
    bus.out_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic collect_grants(input int cycles);
    g_ids.delete(); g_cyc.delete(); g_dat.delete();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.gnt != 4'b0000) begin
        g_ids.push_back(oh_idx(bus.gnt));
        g_cyc.push_back(i);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) g_dat.push_back(int'(bus.out_data));
    end
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] pend;
  logic [3:0] g;

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_gnt",       bus.gnt,       0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_out_id",    bus.out_id,    0);
    chk("rst_busy",      busy,          0);
    chk("rst_state",     state_dbg,     0);
    rst = 1'b0;

    // No requests: stays idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy",  busy,          0);
      chk("idle_gnt",   bus.gnt,       0);
      chk("idle_valid", bus.out_valid, 0);
    end

    // Single request, requester 0 first after reset
    bus.req = 4'b0001;
    set_word(0, 8'hA5);
    @(negedge clk);
    chk("t1_gnt",  bus.gnt, 4'b0001);
    chk("t1_busy", busy,    1);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_data",  bus.out_data,  4'h5);
    chk("t1_id",    bus.out_id,    0);
    chk("t1_gnt_off", bus.gnt,     0);
    @(negedge clk);
    chk("t1_valid_drop", bus.out_valid, 0);
    chk("t1_data_kept",  bus.out_data,  4'h5);
    chk("t1_busy_drop",  busy,          0);

    // All four requesting: strict rotation, one grant per 3 cycles
    do_reset();
    set_word(0, 8'h10); set_word(1, 8'h21); set_word(2, 8'h32); set_word(3, 8'h43);
    bus.req = 4'b1111;
    collect_grants(13);
    chk("t2_count", g_ids.size(), 5);
    if (g_cyc.size() > 0) chk("t2_first_cycle", g_cyc[0], 0);
    for (int k = 0; k < g_ids.size(); k++) chk("t2_order", g_ids[k], k % 4);
    for (int k = 1; k < g_cyc.size(); k++) chk("t2_spacing", g_cyc[k] - g_cyc[k-1], 3);
    chk("t2_data_count", g_dat.size(), 4);
    for (int k = 0; k < g_dat.size(); k++) chk("t2_data", g_dat[k], k);
    drain(4);

    // Backpressure on requester 2; requester 0 waits through the stall
    bus.req = 4'b0100;
    set_word(2, 8'h5A);
    @(negedge clk);
    chk("t3_gnt", bus.gnt, 4'b0100);
    bus.req = 4'b0001;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_valid", bus.out_valid, 1);
      chk("t3_stall_data",  bus.out_data,  4'hA);
      chk("t3_stall_id",    bus.out_id,    2);
      chk("t3_stall_gnt",   bus.gnt,       0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_done_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("t3_next_gnt", bus.gnt, 4'b0001);
    drain(4);

    // Wrap past id 3
    bus.req = 4'b1000;
    @(negedge clk);
    chk("t4_gnt3", bus.gnt, 4'b1000);
    bus.req = 4'b1001;
    collect_grants(6);
    chk("t4_count", g_ids.size(), 2);
    if (g_ids.size() > 0) chk("t4_first", g_ids[0], 0);
    if (g_ids.size() > 1) chk("t4_second", g_ids[1], 3);
    if (g_cyc.size() > 0) chk("t4_first_cycle", g_cyc[0], 2);
    drain(4);

    // Reset while in the grant cycle discards the transfer
    bus.req = 4'b0010;
    set_word(1, 8'h7C);
    @(negedge clk);
    chk("t5_gnt", bus.gnt, 4'b0010);
    chk("t5_state_grant", state_dbg, 1);
    rst = 1'b1;
    bus.req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_gnt",   bus.gnt,       0);
    chk("t5_valid", bus.out_valid, 0);
    chk("t5_data",  bus.out_data,  0);
    chk("t5_busy",  busy,          0);
    chk("t5_state", state_dbg,     0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_valid", bus.out_valid, 0);
    end

    // Randomized traffic with backpressure, data churn and occasional reset
    pend = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      g = bus.gnt;
      for (int i = 0; i < 4; i++) begin
        if (pend[i] && g[i]) begin
          pend[i] = 1'($urandom_range(0, 1));
          set_word(i, 8'($urandom));
        end else if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) pend[i] = 1'b1;
          set_word(i, 8'($urandom));
        end
      end
      bus.req = pend;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0;
    drain(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
